// File: rtl/alu_operand_stage_pkg.sv
// Shared definitions for the ID/EX operand stage: default widths,
// forwarding select encodings and the hard-wired zero register index.
package alu_operand_stage_pkg;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int FUN_W  = 6;

  // Register 0 always reads as zero, so it is never a forwarding source.
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Operand source chosen by the forwarding mux.
  typedef enum logic [1:0] {
    FWD_REG = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

endpackage

// File: rtl/alu_operand_stage_fwd_select.sv
// One forwarding mux for a single EX source operand: picks the youngest
// in-flight producer (EX/MEM before MEM/WB) or falls back to stored data.
module alu_operand_stage_fwd_select #(
  parameter int DATA_W = alu_operand_stage_pkg::DATA_W,
  parameter int REG_W  = alu_operand_stage_pkg::REG_W
) (
  input  logic [REG_W-1:0]  src,
  input  logic [DATA_W-1:0] data,
  input  logic              mem_reg_write,
  input  logic [REG_W-1:0]  mem_dst,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_reg_write,
  input  logic [REG_W-1:0]  wb_dst,
  input  logic [DATA_W-1:0] wb_result,
  output logic [DATA_W-1:0] fwd_data
);
  import alu_operand_stage_pkg::*;

  logic     mem_hit;
  logic     wb_hit;
  fwd_sel_e sel;

  assign mem_hit = mem_reg_write && (mem_dst != REG_W'(REG_ZERO)) && (mem_dst == src);
  assign wb_hit  = wb_reg_write  && (wb_dst  != REG_W'(REG_ZERO)) && (wb_dst  == src);

  // Priority encode the source: the EX/MEM result is newer than MEM/WB.
  always_comb begin
    sel = FWD_REG;
    if (mem_hit) begin
      sel = FWD_MEM;
    end else if (wb_hit) begin
      sel = FWD_WB;
    end
  end

  // Steer the selected value onto the operand.
  always_comb begin
    case (sel)
      FWD_MEM: fwd_data = mem_result;
      FWD_WB:  fwd_data = wb_result;
      default: fwd_data = data;
    endcase
  end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX pipeline register with EX-stage operand forwarding, operand
// selection for the ALU and load-use hazard detection.
module alu_operand_stage #(
  parameter int DATA_W = alu_operand_stage_pkg::DATA_W,
  parameter int REG_W  = alu_operand_stage_pkg::REG_W,
  parameter int FUN_W  = alu_operand_stage_pkg::FUN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_dst,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [4:0]        id_shamt,
  input  logic              id_b_imm,
  input  logic              id_a_shamt,
  input  logic [FUN_W-1:0]  id_alufun,
  input  logic              id_sign,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_reg_write,
  input  logic              flush,
  input  logic              mem_reg_write,
  input  logic [REG_W-1:0]  mem_dst,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_reg_write,
  input  logic [REG_W-1:0]  wb_dst,
  input  logic [DATA_W-1:0] wb_result,
  output logic              stall,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [FUN_W-1:0]  alu_fun,
  output logic              alu_sign,
  output logic [DATA_W-1:0] ex_store_data,
  output logic              ex_valid,
  output logic [REG_W-1:0]  ex_dst,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write
);
  import alu_operand_stage_pkg::*;

  // ---- ID side: capture-time decisions ----
  logic              bubble;
  logic              wb_rs_hit;
  logic              wb_rt_hit;
  logic [DATA_W-1:0] rs_data_in;
  logic [DATA_W-1:0] rt_data_in;

  // ---- EX stage (_p1) state ----
  logic              vld_p1;
  logic              reg_write_p1;
  logic              mem_read_p1;
  logic              mem_write_p1;
  logic [REG_W-1:0]  rs_p1;
  logic [REG_W-1:0]  rt_p1;
  logic [REG_W-1:0]  dst_p1;
  logic [DATA_W-1:0] rs_data_p1;
  logic [DATA_W-1:0] rt_data_p1;
  logic [DATA_W-1:0] imm_p1;
  logic [4:0]        shamt_p1;
  logic              b_imm_p1;
  logic              a_shamt_p1;
  logic [FUN_W-1:0]  fun_p1;
  logic              sign_p1;

  logic [DATA_W-1:0] fwd_rs;
  logic [DATA_W-1:0] fwd_rt;

  // A load in EX whose result a valid ID instruction needs cannot be
  // forwarded in time; hold ID and insert a bubble instead.
  assign stall = vld_p1 && mem_read_p1 && (dst_p1 != REG_W'(REG_ZERO)) && id_valid &&
                 ((dst_p1 == id_rs) || (dst_p1 == id_rt));

  // Flush dominates, but either one turns the captured entry into a bubble.
  assign bubble = flush || stall;

  // The register file is read before it is written in the same cycle, so
  // pick up the value being written back while it is still visible.
  assign wb_rs_hit  = wb_reg_write && (wb_dst != REG_W'(REG_ZERO)) && (wb_dst == id_rs);
  assign wb_rt_hit  = wb_reg_write && (wb_dst != REG_W'(REG_ZERO)) && (wb_dst == id_rt);
  assign rs_data_in = wb_rs_hit ? wb_result : id_rs_data;
  assign rt_data_in = wb_rt_hit ? wb_result : id_rt_data;

  // ==== ID -> EX boundary ====
  // Control half of the pipeline register; bubbles clear valid and side effects.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1       <= 1'b0;
      reg_write_p1 <= 1'b0;
      mem_read_p1  <= 1'b0;
      mem_write_p1 <= 1'b0;
    end else begin
      vld_p1       <= id_valid && !bubble;
      reg_write_p1 <= id_valid && !bubble && id_reg_write;
      mem_read_p1  <= id_valid && !bubble && id_mem_read;
      mem_write_p1 <= id_valid && !bubble && id_mem_write;
    end
  end

  // Data half of the pipeline register; captured every edge, meaningless in a bubble.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs_p1      <= '0;
      rt_p1      <= '0;
      dst_p1     <= '0;
      rs_data_p1 <= '0;
      rt_data_p1 <= '0;
      imm_p1     <= '0;
      shamt_p1   <= '0;
      b_imm_p1   <= 1'b0;
      a_shamt_p1 <= 1'b0;
      fun_p1     <= '0;
      sign_p1    <= 1'b0;
    end else begin
      rs_p1      <= id_rs;
      rt_p1      <= id_rt;
      dst_p1     <= id_dst;
      rs_data_p1 <= rs_data_in;
      rt_data_p1 <= rt_data_in;
      imm_p1     <= id_imm;
      shamt_p1   <= id_shamt;
      b_imm_p1   <= id_b_imm;
      a_shamt_p1 <= id_a_shamt;
      fun_p1     <= id_alufun;
      sign_p1    <= id_sign;
    end
  end

  // ==== EX stage: forwarding and operand select ====
  alu_operand_stage_fwd_select #(
    .DATA_W (DATA_W),
    .REG_W  (REG_W)
  ) u_fwd_rs (
    .src           (rs_p1),
    .data          (rs_data_p1),
    .mem_reg_write (mem_reg_write),
    .mem_dst       (mem_dst),
    .mem_result    (mem_result),
    .wb_reg_write  (wb_reg_write),
    .wb_dst        (wb_dst),
    .wb_result     (wb_result),
    .fwd_data      (fwd_rs)
  );

  alu_operand_stage_fwd_select #(
    .DATA_W (DATA_W),
    .REG_W  (REG_W)
  ) u_fwd_rt (
    .src           (rt_p1),
    .data          (rt_data_p1),
    .mem_reg_write (mem_reg_write),
    .mem_dst       (mem_dst),
    .mem_result    (mem_result),
    .wb_reg_write  (wb_reg_write),
    .wb_dst        (wb_dst),
    .wb_result     (wb_result),
    .fwd_data      (fwd_rt)
  );

  assign alu_a         = a_shamt_p1 ? {{(DATA_W-5){1'b0}}, shamt_p1} : fwd_rs;
  assign alu_b         = b_imm_p1 ? imm_p1 : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign alu_fun       = fun_p1;
  assign alu_sign      = sign_p1;
  assign ex_valid      = vld_p1;
  assign ex_dst        = dst_p1;
  assign ex_reg_write  = vld_p1 && reg_write_p1;
  assign ex_mem_read   = vld_p1 && mem_read_p1;
  assign ex_mem_write  = vld_p1 && mem_write_p1;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: expected EX outputs are pushed
// to a scoreboard when an instruction is driven and popped after capture.
module tb_alu_operand_stage;
  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int FUN_W  = 6;

  logic              clk = 1'b0;
  logic              reset;
  logic              id_valid;
  logic [REG_W-1:0]  id_rs, id_rt, id_dst;
  logic [DATA_W-1:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]        id_shamt;
  logic              id_b_imm, id_a_shamt;
  logic [FUN_W-1:0]  id_alufun;
  logic              id_sign, id_mem_read, id_mem_write, id_reg_write;
  logic              flush;
  logic              mem_reg_write;
  logic [REG_W-1:0]  mem_dst;
  logic [DATA_W-1:0] mem_result;
  logic              wb_reg_write;
  logic [REG_W-1:0]  wb_dst;
  logic [DATA_W-1:0] wb_result;
  logic              stall;
  logic [DATA_W-1:0] alu_a, alu_b, ex_store_data;
  logic [FUN_W-1:0]  alu_fun;
  logic              alu_sign, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
  logic [REG_W-1:0]  ex_dst;

  typedef struct {
    logic        valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] st;
    logic [5:0]  fun;
    logic        rw;
    logic        mr;
    logic        mw;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  alu_operand_stage dut (
    .clk           (clk),
    .reset         (reset),
    .id_valid      (id_valid),
    .id_rs         (id_rs),
    .id_rt         (id_rt),
    .id_dst        (id_dst),
    .id_rs_data    (id_rs_data),
    .id_rt_data    (id_rt_data),
    .id_imm        (id_imm),
    .id_shamt      (id_shamt),
    .id_b_imm      (id_b_imm),
    .id_a_shamt    (id_a_shamt),
    .id_alufun     (id_alufun),
    .id_sign       (id_sign),
    .id_mem_read   (id_mem_read),
    .id_mem_write  (id_mem_write),
    .id_reg_write  (id_reg_write),
    .flush         (flush),
    .mem_reg_write (mem_reg_write),
    .mem_dst       (mem_dst),
    .mem_result    (mem_result),
    .wb_reg_write  (wb_reg_write),
    .wb_dst        (wb_dst),
    .wb_result     (wb_result),
    .stall         (stall),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_fun       (alu_fun),
    .alu_sign      (alu_sign),
    .ex_store_data (ex_store_data),
    .ex_valid      (ex_valid),
    .ex_dst        (ex_dst),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk_exp(input logic v, input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] st, input logic [5:0] fun,
                                  input logic rw, input logic mr, input logic mw);
    exp_t x;
    x.valid = v; x.a = a; x.b = b; x.st = st; x.fun = fun;
    x.rw = v & rw; x.mr = v & mr; x.mw = v & mw;
    return x;
  endfunction

  task clear_inputs();
    id_valid = 0; id_rs = 0; id_rt = 0; id_dst = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm = 0; id_shamt = 0;
    id_b_imm = 0; id_a_shamt = 0; id_alufun = 0; id_sign = 0;
    id_mem_read = 0; id_mem_write = 0; id_reg_write = 0; flush = 0;
    mem_reg_write = 0; mem_dst = 0; mem_result = 0;
    wb_reg_write = 0; wb_dst = 0; wb_result = 0;
  endtask

  task drive_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dst,
                input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm,
                input logic [4:0] sh, input logic bimm, input logic ashamt,
                input logic [5:0] fun, input logic sgn,
                input logic mr, input logic mw, input logic rw);
    id_valid = 1; id_rs = rs; id_rt = rt; id_dst = dst;
    id_rs_data = rsd; id_rt_data = rtd; id_imm = imm; id_shamt = sh;
    id_b_imm = bimm; id_a_shamt = ashamt; id_alufun = fun; id_sign = sgn;
    id_mem_read = mr; id_mem_write = mw; id_reg_write = rw;
  endtask

  task test_reset();
    reset = 1; clear_inputs();
    @(negedge clk);
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", ex_valid); end
    checks++; if (alu_a !== 32'h0) begin errors++; $display("FAIL rst_alu_a got %h want 0", alu_a); end
    checks++; if (alu_fun !== 6'h0 || alu_sign !== 1'b0) begin errors++; $display("FAIL rst_fun got %h/%b want 0/0", alu_fun, alu_sign); end
    reset = 0;
    // load r4 from r1 enters EX, then a dependent instruction raises stall
    @(negedge clk);
    drive_id(5'd1, 5'd0, 5'd4, 32'hAAAA_0000, 32'h0, 32'h8, 5'd0, 1'b1, 1'b0, 6'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    sb.push_back(mk_exp(1'b1, 32'hAAAA_0000, 32'h8, 32'h0, 6'h00, 1'b1, 1'b1, 1'b0));
    @(posedge clk); #1;
    drive_id(5'd4, 5'd0, 5'd6, 32'h1, 32'h2, 32'h0, 5'd0, 1'b0, 1'b0, 6'h20, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    e = sb.pop_front();
    checks++; if (ex_valid !== e.valid || alu_a !== e.a || alu_b !== e.b || ex_mem_read !== e.mr)
      begin errors++; $display("FAIL rst_pre_load got v=%b a=%h b=%h mr=%b want v=%b a=%h b=%h mr=%b", ex_valid, alu_a, alu_b, ex_mem_read, e.valid, e.a, e.b, e.mr); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rst_pre_stall got %b want 1", stall); end
    // asynchronous reset between edges takes effect at once
    reset = 1;
    #1;
    checks++; if (ex_valid !== 1'b0 || alu_a !== 32'h0 || alu_b !== 32'h0 || stall !== 1'b0 || ex_reg_write !== 1'b0)
      begin errors++; $display("FAIL rst_async got v=%b a=%h b=%h stall=%b rw=%b want 0", ex_valid, alu_a, alu_b, stall, ex_reg_write); end
    @(negedge clk);
    reset = 0; clear_inputs();
  endtask

  task test_mem_fwd();
    @(negedge clk); clear_inputs();
    drive_id(5'd3, 5'd0, 5'd7, 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 6'h20, 1'b1, 1'b0, 1'b0, 1'b1);
    sb.push_back(mk_exp(1'b1, 32'hDEAD_BEEF, 32'h0, 32'h0, 6'h20, 1'b1, 1'b0, 1'b0));
    sb.push_back(mk_exp(1'b1, 32'h0000_0010, 32'h0, 32'h0, 6'h20, 1'b1, 1'b0, 1'b0));
    @(posedge clk); #1;
    id_valid = 0;
    e = sb.pop_front();
    checks++; if (alu_a !== e.a || alu_fun !== e.fun || ex_reg_write !== e.rw || alu_sign !== 1'b1 || ex_dst !== 5'd7)
      begin errors++; $display("FAIL mem_fwd_none got a=%h fun=%h rw=%b sign=%b dst=%0d want a=%h fun=%h rw=%b sign=1 dst=7", alu_a, alu_fun, ex_reg_write, alu_sign, ex_dst, e.a, e.fun, e.rw); end
    mem_reg_write = 1; mem_dst = 5'd3; mem_result = 32'h0000_0010;
    #1;
    e = sb.pop_front();
    checks++; if (alu_a !== e.a || ex_valid !== e.valid) begin errors++; $display("FAIL mem_fwd got a=%h v=%b want a=%h v=%b", alu_a, ex_valid, e.a, e.valid); end
  endtask

  task test_priority();
    @(negedge clk); clear_inputs();
    drive_id(5'd0, 5'd5, 5'd8, 32'h0, 32'h55, 32'h0, 5'd0, 1'b0, 1'b0, 6'h21, 1'b0, 1'b0, 1'b0, 1'b1);
    sb.push_back(mk_exp(1'b1, 32'h0, 32'h11, 32'h11, 6'h21, 1'b1, 1'b0, 1'b0));
    sb.push_back(mk_exp(1'b1, 32'h0, 32'h22, 32'h22, 6'h21, 1'b1, 1'b0, 1'b0));
    sb.push_back(mk_exp(1'b1, 32'h0, 32'h55, 32'h55, 6'h21, 1'b1, 1'b0, 1'b0));
    @(posedge clk); #1;
    id_valid = 0;
    mem_reg_write = 1; mem_dst = 5'd5; mem_result = 32'h11;
    wb_reg_write = 1; wb_dst = 5'd5; wb_result = 32'h22;
    #1;
    e = sb.pop_front();
    checks++; if (alu_b !== e.b || ex_store_data !== e.st) begin errors++; $display("FAIL prio_mem got b=%h st=%h want b=%h st=%h", alu_b, ex_store_data, e.b, e.st); end
    mem_reg_write = 0;
    #1;
    e = sb.pop_front();
    checks++; if (alu_b !== e.b || ex_store_data !== e.st) begin errors++; $display("FAIL prio_wb got b=%h st=%h want b=%h st=%h", alu_b, ex_store_data, e.b, e.st); end
    wb_reg_write = 0;
    #1;
    e = sb.pop_front();
    checks++; if (alu_b !== e.b || ex_store_data !== e.st) begin errors++; $display("FAIL prio_reg got b=%h st=%h want b=%h st=%h", alu_b, ex_store_data, e.b, e.st); end
  endtask

  task test_reg0();
    @(negedge clk); clear_inputs();
    drive_id(5'd0, 5'd0, 5'd9, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 6'h20, 1'b0, 1'b0, 1'b0, 1'b1);
    sb.push_back(mk_exp(1'b1, 32'h0, 32'h0, 32'h0, 6'h20, 1'b1, 1'b0, 1'b0));
    @(posedge clk); #1;
    id_valid = 0;
    mem_reg_write = 1; mem_dst = 5'd0; mem_result = 32'hFFFF_FFFF;
    wb_reg_write = 1; wb_dst = 5'd0; wb_result = 32'h1234_5678;
    #1;
    e = sb.pop_front();
    checks++; if (alu_a !== e.a || ex_store_data !== e.st) begin errors++; $display("FAIL reg0 got a=%h st=%h want a=%h st=%h", alu_a, ex_store_data, e.a, e.st); end
  endtask

  task test_capture_bypass();
    @(negedge clk); clear_inputs();
    drive_id(5'd7, 5'd9, 5'd10, 32'h1, 32'h2, 32'h0, 5'd0, 1'b0, 1'b0, 6'h20, 1'b0, 1'b0, 1'b0, 1'b1);
    wb_reg_write = 1; wb_dst = 5'd7; wb_result = 32'h77;
    sb.push_back(mk_exp(1'b1, 32'h77, 32'h2, 32'h2, 6'h20, 1'b1, 1'b0, 1'b0));
    @(posedge clk); #1;
    wb_reg_write = 0; wb_dst = 0; wb_result = 0;
    #1;
    e = sb.pop_front();
    checks++; if (alu_a !== e.a || alu_b !== e.b) begin errors++; $display("FAIL cap_bypass got a=%h b=%h want a=%h b=%h", alu_a, alu_b, e.a, e.b); end
    // shift amount overrides even an active forward on rs
    @(negedge clk); clear_inputs();
    drive_id(5'd7, 5'd9, 5'd10, 32'h1, 32'h2, 32'h0, 5'd13, 1'b0, 1'b1, 6'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    sb.push_back(mk_exp(1'b1, 32'd13, 32'h2, 32'h2, 6'h00, 1'b1, 1'b0, 1'b0));
    @(posedge clk); #1;
    id_valid = 0;
    mem_reg_write = 1; mem_dst = 5'd7; mem_result = 32'hABCD;
    #1;
    e = sb.pop_front();
    checks++; if (alu_a !== e.a) begin errors++; $display("FAIL shamt_sel got a=%h want a=%h", alu_a, e.a); end
  endtask

  task test_load_use();
    @(negedge clk); clear_inputs();
    drive_id(5'd1, 5'd0, 5'd4, 32'h100, 32'h0, 32'h8, 5'd0, 1'b1, 1'b0, 6'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    drive_id(5'd2, 5'd4, 5'd6, 32'h3, 32'hBAD, 32'h0, 5'd0, 1'b0, 1'b0, 6'h22, 1'b0, 1'b0, 1'b0, 1'b1);
    #1;
    checks++; if (stall !== 1'b1 || ex_mem_read !== 1'b1) begin errors++; $display("FAIL lu_stall got stall=%b mr=%b want 1/1", stall, ex_mem_read); end
    sb.push_back(mk_exp(1'b0, 32'h0, 32'h0, 32'h0, 6'h0, 1'b0, 1'b0, 1'b0));
    @(posedge clk); #1;
    mem_reg_write = 1; mem_dst = 5'd4; mem_result = 32'h108;
    #1;
    e = sb.pop_front();
    checks++; if (ex_valid !== e.valid || ex_reg_write !== e.rw || ex_mem_read !== e.mr || ex_mem_write !== e.mw)
      begin errors++; $display("FAIL lu_bubble got v=%b rw=%b mr=%b mw=%b want v=%b rw=%b mr=%b mw=%b", ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, e.valid, e.rw, e.mr, e.mw); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_release got stall=%b want 0", stall); end
    sb.push_back(mk_exp(1'b1, 32'h3, 32'hCAFE, 32'hCAFE, 6'h22, 1'b1, 1'b0, 1'b0));
    @(posedge clk); #1;
    id_valid = 0;
    mem_reg_write = 0; mem_dst = 0; mem_result = 0;
    wb_reg_write = 1; wb_dst = 5'd4; wb_result = 32'hCAFE;
    #1;
    e = sb.pop_front();
    checks++; if (ex_valid !== e.valid || alu_a !== e.a || alu_b !== e.b || ex_store_data !== e.st || alu_fun !== e.fun)
      begin errors++; $display("FAIL lu_recapture got v=%b a=%h b=%h st=%h fun=%h want v=%b a=%h b=%h st=%h fun=%h", ex_valid, alu_a, alu_b, ex_store_data, alu_fun, e.valid, e.a, e.b, e.st, e.fun); end
  endtask

  task test_flush();
    @(negedge clk); clear_inputs();
    drive_id(5'd1, 5'd0, 5'd4, 32'h100, 32'h0, 32'h8, 5'd0, 1'b1, 1'b0, 6'h00, 1'b0, 1'b1, 1'b0, 1'b1);
    @(posedge clk); #1;
    drive_id(5'd2, 5'd4, 5'd6, 32'h3, 32'h4, 32'h0, 5'd0, 1'b0, 1'b0, 6'h22, 1'b0, 1'b0, 1'b1, 1'b1);
    flush = 1;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL fl_stall got %b want 1", stall); end
    sb.push_back(mk_exp(1'b0, 32'h0, 32'h0, 32'h0, 6'h0, 1'b0, 1'b0, 1'b0));
    @(posedge clk); #1;
    e = sb.pop_front();
    checks++; if (ex_valid !== e.valid || ex_reg_write !== e.rw || ex_mem_write !== e.mw)
      begin errors++; $display("FAIL fl_bubble got v=%b rw=%b mw=%b want v=%b rw=%b mw=%b", ex_valid, ex_reg_write, ex_mem_write, e.valid, e.rw, e.mw); end
    flush = 0;
    drive_id(5'd1, 5'd2, 5'd0, 32'h5, 32'h6, 32'hFFFF_FFFC, 5'd0, 1'b1, 1'b0, 6'h23, 1'b1, 1'b0, 1'b1, 1'b0);
    sb.push_back(mk_exp(1'b1, 32'h5, 32'hFFFF_FFFC, 32'h6, 6'h23, 1'b0, 1'b0, 1'b1));
    @(posedge clk); #1;
    id_valid = 0;
    #1;
    e = sb.pop_front();
    checks++; if (ex_valid !== e.valid || alu_a !== e.a || alu_b !== e.b || ex_store_data !== e.st || ex_mem_write !== e.mw || ex_reg_write !== e.rw)
      begin errors++; $display("FAIL fl_imm got v=%b a=%h b=%h st=%h mw=%b rw=%b want v=%b a=%h b=%h st=%h mw=%b rw=%b", ex_valid, alu_a, alu_b, ex_store_data, ex_mem_write, ex_reg_write, e.valid, e.a, e.b, e.st, e.mw, e.rw); end
  endtask

  task test_back_to_back();
    logic [4:0]  rs, rt, dst, sh;
    logic [31:0] rsd, rtd, imm;
    logic        bimm, ashamt, sgn, mw, rw, v;
    logic [5:0]  fun;
    @(negedge clk); clear_inputs();
    for (int i = 0; i < 10; i++) begin
      rs = 5'($urandom_range(1, 31)); rt = 5'($urandom_range(1, 31)); dst = 5'($urandom_range(1, 31));
      rsd = $urandom; rtd = $urandom; imm = $urandom; sh = 5'($urandom);
      bimm = 1'($urandom); ashamt = 1'($urandom); sgn = 1'($urandom);
      mw = 1'($urandom); rw = 1'($urandom); v = (i % 4 != 3); fun = 6'($urandom);
      drive_id(rs, rt, dst, rsd, rtd, imm, sh, bimm, ashamt, fun, sgn, 1'b0, mw, rw);
      id_valid = v;
      sb.push_back(mk_exp(v, ashamt ? {27'b0, sh} : rsd, bimm ? imm : rtd, rtd, fun, rw, 1'b0, mw));
      @(posedge clk); #1;
      e = sb.pop_front();
      checks++;
      if (ex_valid !== e.valid || alu_a !== e.a || alu_b !== e.b || ex_store_data !== e.st ||
          alu_fun !== e.fun || ex_reg_write !== e.rw || ex_mem_read !== e.mr || ex_mem_write !== e.mw) begin
        errors++;
        $display("FAIL b2b_%0d got v=%b a=%h b=%h st=%h fun=%h rw=%b mr=%b mw=%b want v=%b a=%h b=%h st=%h fun=%h rw=%b mr=%b mw=%b",
                 i, ex_valid, alu_a, alu_b, ex_store_data, alu_fun, ex_reg_write, ex_mem_read, ex_mem_write,
                 e.valid, e.a, e.b, e.st, e.fun, e.rw, e.mr, e.mw);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mem_fwd();
    test_priority();
    test_reg0();
    test_capture_bypass();
    test_load_use();
    test_flush();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
